// File: rtl/complete_tx_queue_pkg.sv
// Shared widths and packet types for the FU -> complete-stage transmit queue.
// These are the packet layouts the complete stage already expects: one result
// packet per FU and one bit per FU for the finish/stall vectors.
package complete_tx_queue_pkg;

  localparam int NUM_FU     = 8;
  localparam int LANE_DEPTH = 2;

  typedef struct packed {
    logic [5:0]  dest_pr;
    logic [31:0] dest_value;
    logic [4:0]  rob_entry;
    logic        if_take_branch;
    logic [31:0] target_pc;
  } FU_COMPLETE_PACKET;

  typedef logic [NUM_FU-1:0] FU_STATE_PACKET;

endpackage

// File: rtl/complete_tx_lane.sv
// One lane of the transmit queue: a small FIFO of finished results, the
// request/ready logic facing the FU and the complete stage, and the output
// register the complete stage reads one cycle after granting this lane.
// Optional feature: COMPLETE_TX_BYPASS_EN lets an empty lane request in the
// arrival cycle and hand the incoming packet straight to the output register.
module complete_tx_lane
  import complete_tx_queue_pkg::*;
#(
  parameter int LANE_DEPTH_P = LANE_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_squash,
  input  logic              i_inValid,
  input  FU_COMPLETE_PACKET i_inPkt,
  output logic              o_inReady,
  input  logic              i_stall,
  output logic              o_finish,
  output FU_COMPLETE_PACKET o_outPkt
);

  localparam int PW = (LANE_DEPTH_P > 1) ? $clog2(LANE_DEPTH_P) : 1;
  localparam int CW = $clog2(LANE_DEPTH_P) + 1;

  FU_COMPLETE_PACKET r_mem [LANE_DEPTH_P];
  FU_COMPLETE_PACKET r_outPkt;
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic w_empty;
  logic w_full;
  logic w_request;
  logic w_grant;
  logic w_ready;
  logic w_pop;
  logic w_push;

  // Request, grant, ready and FIFO push/pop decisions for this cycle
  always_comb begin
    w_empty   = (r_count == '0);
    w_full    = (r_count == CW'(LANE_DEPTH_P));
`ifdef COMPLETE_TX_BYPASS_EN
    w_request = (~w_empty | i_inValid) & ~i_squash;
`else
    w_request = ~w_empty & ~i_squash;
`endif
    w_grant   = w_request & ~i_stall;
    w_ready   = ~w_full | w_grant;
    w_pop     = w_grant & ~w_empty;
    // A grant on an empty lane consumes the incoming packet directly
    w_push    = i_inValid & w_ready & ~i_squash & ~(w_grant & w_empty);
  end

  // Pointer, occupancy and output-register state; squash empties the FIFO
  // but keeps the output register so an earlier grant is still readable
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_outPkt <= '0;
    end else if (i_squash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_grant) r_outPkt <= w_empty ? i_inPkt : r_mem[r_head];
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are meaningless while count says empty
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_tail] <= i_inPkt;
  end

  assign o_finish  = w_request;
  assign o_inReady = w_ready;
  assign o_outPkt  = r_outPkt;

endmodule

// File: rtl/complete_tx_queue.sv
// Producer side of the FU -> complete-stage handshake. Buffers results from
// the eight FU pipelines in per-lane FIFOs, raises fu_finish per lane and
// holds each granted packet on fu_c_in for the cycle after the grant.
// Optional feature: COMPLETE_TX_BYPASS_EN (see complete_tx_lane).
module complete_tx_queue
  import complete_tx_queue_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           squash,
  input  logic [NUM_FU-1:0]              fu_in_valid,
  input  FU_COMPLETE_PACKET [NUM_FU-1:0] fu_in_pkt,
  output logic [NUM_FU-1:0]              fu_in_ready,
  input  FU_STATE_PACKET                 fu_c_stall,
  output FU_STATE_PACKET                 fu_finish,
  output FU_COMPLETE_PACKET [NUM_FU-1:0] fu_c_in
);

  // One independent lane per FU; the top only slices vectors and fans out squash
  for (genvar g = 0; g < NUM_FU; g++) begin : g_lane
    complete_tx_lane #(
      .LANE_DEPTH_P (LANE_DEPTH)
    ) u_lane (
      .clock     (clock),
      .reset     (reset),
      .i_squash  (squash),
      .i_inValid (fu_in_valid[g]),
      .i_inPkt   (fu_in_pkt[g]),
      .o_inReady (fu_in_ready[g]),
      .i_stall   (fu_c_stall[g]),
      .o_finish  (fu_finish[g]),
      .o_outPkt  (fu_c_in[g])
    );
  end

endmodule

// File: tb/tb_complete_tx_queue.sv
// Randomized self-checking bench for complete_tx_queue. A queue-based model
// per lane tracks buffered results and the last granted packet.
module tb_complete_tx_queue;
  import complete_tx_queue_pkg::*;

  logic                           clock;
  logic                           reset;
  logic                           squash;
  logic [NUM_FU-1:0]              fu_in_valid;
  FU_COMPLETE_PACKET [NUM_FU-1:0] fu_in_pkt;
  logic [NUM_FU-1:0]              fu_in_ready;
  FU_STATE_PACKET                 fu_c_stall;
  FU_STATE_PACKET                 fu_finish;
  FU_COMPLETE_PACKET [NUM_FU-1:0] fu_c_in;

  complete_tx_queue dut (
    .clock       (clock),
    .reset       (reset),
    .squash      (squash),
    .fu_in_valid (fu_in_valid),
    .fu_in_pkt   (fu_in_pkt),
    .fu_in_ready (fu_in_ready),
    .fu_c_stall  (fu_c_stall),
    .fu_finish   (fu_finish),
    .fu_c_in     (fu_c_in)
  );

  int checks = 0;
  int failures = 0;

  FU_COMPLETE_PACKET modelQ [NUM_FU][$];
  FU_COMPLETE_PACKET modelOut [NUM_FU];

  // Free-running clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic FU_COMPLETE_PACKET randPkt();
    logic [95:0] raw;
    raw = {$urandom(), $urandom(), $urandom()};
    return raw[$bits(FU_COMPLETE_PACKET)-1:0];
  endfunction

  // Expected request for a lane given model occupancy and current inputs
  function automatic logic expFinish(input int i);
    logic req;
    req = (modelQ[i].size() != 0);
`ifdef COMPLETE_TX_BYPASS_EN
    req = req | fu_in_valid[i];
`endif
    return req & ~squash;
  endfunction

  // Drive one cycle of inputs at the falling edge, check outputs, then
  // advance the model at the rising edge using the inputs that were sampled
  task automatic applyStimulus(input bit rst, input bit sq, input logic [NUM_FU-1:0] vld,
                               input logic [NUM_FU-1:0] stl);
    logic             f;
    logic             g;
    logic             rdy;
    logic             consumed;
    FU_COMPLETE_PACKET p;
    @(negedge clock);
    reset       = rst;
    squash      = sq;
    fu_in_valid = vld;
    fu_c_stall  = stl;
    for (int i = 0; i < NUM_FU; i++) fu_in_pkt[i] = randPkt();
    #1;
    for (int i = 0; i < NUM_FU; i++) begin
      f   = expFinish(i);
      g   = f & ~stl[i];
      rdy = (modelQ[i].size() < LANE_DEPTH) | g;
      checkOutput($sformatf("finish[%0d]", i), 128'(fu_finish[i]), 128'(f));
      checkOutput($sformatf("ready[%0d]", i), 128'(fu_in_ready[i]), 128'(rdy));
      checkOutput($sformatf("c_in[%0d]", i), 128'(fu_c_in[i]), 128'(modelOut[i]));
    end
    @(posedge clock);
    for (int i = 0; i < NUM_FU; i++) begin
      if (rst) begin
        modelQ[i].delete();
        modelOut[i] = '0;
      end else if (sq) begin
        modelQ[i].delete();
      end else begin
        f        = expFinish(i);
        g        = f & ~stl[i];
        rdy      = (modelQ[i].size() < LANE_DEPTH) | g;
        consumed = 1'b0;
        if (g) begin
          if (modelQ[i].size() != 0) begin
            p = modelQ[i].pop_front();
            modelOut[i] = p;
          end else begin
            modelOut[i] = fu_in_pkt[i];
            consumed = 1'b1;
          end
        end
        if (vld[i] & rdy & ~consumed) modelQ[i].push_back(fu_in_pkt[i]);
      end
    end
  endtask

  function automatic logic [NUM_FU-1:0] randMask(input int pct);
    logic [NUM_FU-1:0] m;
    for (int i = 0; i < NUM_FU; i++) m[i] = ($urandom_range(99) < pct);
    return m;
  endfunction

  // Test sequence: initial reset, idle reset-state checks, then phased
  // random traffic with varying back-pressure, occasional squash and reset
  initial begin
    int stallPct;
    int validPct;
    reset       = 1'b1;
    squash      = 1'b0;
    fu_in_valid = '0;
    fu_c_stall  = '0;
    fu_in_pkt   = '0;
    for (int i = 0; i < NUM_FU; i++) modelOut[i] = '0;
    repeat (2) @(posedge clock);

    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, '0, '0);

    for (int c = 0; c < 3000; c++) begin
      case (c / 500)
        0:       begin stallPct = 50; validPct = 50; end
        1:       begin stallPct = 90; validPct = 80; end
        2:       begin stallPct = 0;  validPct = 70; end
        3:       begin stallPct = 20; validPct = 95; end
        4:       begin stallPct = 100; validPct = 60; end
        default: begin stallPct = 40; validPct = 40; end
      endcase
      applyStimulus(($urandom_range(299) == 0), ($urandom_range(49) == 0),
                    randMask(validPct), randMask(stallPct));
    end

    // Squash on full lanes followed by a drain
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, '1, '1);
    applyStimulus(1'b0, 1'b1, '1, '0);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0, '0, '0);

    // Mid-operation reset with full lanes
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, '1, 8'h1F);
    applyStimulus(1'b1, 1'b0, '1, '0);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
